// File: rtl/eq_lock_tracker.sv
//------------------------------------------------------------------------------
// eq_lock_tracker
//
// Watches the per-cycle result of a 2-bit equality comparator and decides
// whether the incoming pattern is aligned.
// - After LOCK_COUNT consecutive valid matches it declares lock.
// - After UNLOCK_COUNT consecutive valid mismatches, counted from lock, it
//   drops lock again.
// It also keeps a saturating run length of consecutive matches and a
// saturating total of mismatches for error monitoring.
//
// Parameters
//   LOCK_COUNT   : consecutive matches needed to lock (1 .. 2^RUN_W-1)
//   UNLOCK_COUNT : consecutive mismatches needed to unlock (1 .. 15)
//   RUN_W        : width of run_len
//   ERR_W        : width of err_count
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   reset_n      : asynchronous active-low reset
//   clear        : synchronous clear; same effect as reset, wins over valid
//   valid        : eq carries a real sample this cycle
//   eq           : comparator result (1 = operands equal)
//   locked       : high in LOCKED and SLIP
//   lock_pulse   : one-cycle pulse on SEARCH -> LOCKED
//   unlock_pulse : one-cycle pulse on SLIP/LOCKED -> SEARCH
//   state        : SEARCH=00, LOCKED=01, SLIP=10
//   run_len      : consecutive valid matches, saturating
//   err_count    : total valid mismatches since reset/clear, saturating
//------------------------------------------------------------------------------
module eq_lock_tracker #(
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 2,
   parameter int unsigned RUN_W        = 8,
   parameter int unsigned ERR_W        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             valid,
   input  logic             eq,
   output logic             locked,
   output logic             lock_pulse,
   output logic             unlock_pulse,
   output logic [1:0]       state,
   output logic [RUN_W-1:0] run_len,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_LOCKED = 2'b01,
      ST_SLIP   = 2'b10
   } state_t;

   // Lock is declared on the match that brings the run to LOCK_COUNT, so the
   // comparison is against the run length before that match is counted.
   localparam logic [RUN_W-1:0] LOCK_THRESH = RUN_W'(LOCK_COUNT - 1);
   localparam logic [3:0]       UNLOCK_MAX  = 4'(UNLOCK_COUNT);
   localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

   state_t             state_reg,        state_next;
   logic [RUN_W-1:0]   run_reg,          run_next;
   logic [ERR_W-1:0]   err_reg,          err_next;
   logic [3:0]         miss_reg,         miss_next;
   logic               locked_reg,       locked_next;
   logic               lock_pulse_reg,   lock_pulse_next;
   logic               unlock_pulse_reg, unlock_pulse_next;

   logic [3:0]         miss_inc;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_SEARCH;
         run_reg          <= '0;
         err_reg          <= '0;
         miss_reg         <= '0;
         locked_reg       <= 1'b0;
         lock_pulse_reg   <= 1'b0;
         unlock_pulse_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         run_reg          <= run_next;
         err_reg          <= err_next;
         miss_reg         <= miss_next;
         locked_reg       <= locked_next;
         lock_pulse_reg   <= lock_pulse_next;
         unlock_pulse_reg <= unlock_pulse_next;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and output logic
   //---------------------------------------------------------------------------
   assign miss_inc = miss_reg + 4'd1;

   always_comb begin
      state_next        = state_reg;
      run_next          = run_reg;
      err_next          = err_reg;
      miss_next         = miss_reg;
      lock_pulse_next   = 1'b0;
      unlock_pulse_next = 1'b0;

      if (clear) begin
         // The sample presented alongside clear is discarded.
         state_next = ST_SEARCH;
         run_next   = '0;
         err_next   = '0;
         miss_next  = '0;
      end else begin
         // Run and error counters are independent of the FSM state.
         if (valid) begin
            if (eq) begin
               run_next  = (run_reg == '1) ? run_reg : run_reg + RUN_ONE;
               miss_next = '0;
            end else begin
               run_next  = '0;
               err_next  = (err_reg == '1) ? err_reg : err_reg + ERR_ONE;
            end
         end

         case (state_reg)
            ST_SEARCH: begin
               if (valid && eq && (run_reg >= LOCK_THRESH)) begin
                  state_next      = ST_LOCKED;
                  lock_pulse_next = 1'b1;
               end
            end

            ST_LOCKED: begin
               if (valid && !eq) begin
                  if (UNLOCK_COUNT == 1) begin
                     state_next        = ST_SEARCH;
                     unlock_pulse_next = 1'b1;
                     miss_next         = '0;
                  end else begin
                     state_next = ST_SLIP;
                     miss_next  = 4'd1;
                  end
               end
            end

            ST_SLIP: begin
               if (valid) begin
                  if (eq) begin
                     state_next = ST_LOCKED;
                     miss_next  = '0;
                  end else if (miss_inc == UNLOCK_MAX) begin
                     state_next        = ST_SEARCH;
                     unlock_pulse_next = 1'b1;
                     miss_next         = '0;
                  end else begin
                     miss_next = miss_inc;
                  end
               end
            end

            // Encoding 11 cannot be reached; fall back to SEARCH on any edge.
            default: begin
               state_next = ST_SEARCH;
               miss_next  = '0;
            end
         endcase
      end

      // Registered so that locked moves in the same cycle as the pulses.
      locked_next = (state_next == ST_LOCKED) || (state_next == ST_SLIP);
   end

   //---------------------------------------------------------------------------
   // Outputs (all straight from registers)
   //---------------------------------------------------------------------------
   assign state        = state_reg;
   assign run_len      = run_reg;
   assign err_count    = err_reg;
   assign locked       = locked_reg;
   assign lock_pulse   = lock_pulse_reg;
   assign unlock_pulse = unlock_pulse_reg;

endmodule

// File: tb/tb_eq_lock_tracker.sv
//------------------------------------------------------------------------------
// Directed bench for eq_lock_tracker. Three instances share the same stimulus:
// defaults, RUN_W=3 (run_len saturation) and UNLOCK_COUNT=1 (direct unlock).
//------------------------------------------------------------------------------
module tb_eq_lock_tracker;

   logic clk;
   logic reset_n;
   logic clear;
   logic valid;
   logic eq;

   logic       locked, lock_pulse, unlock_pulse;
   logic [1:0] state;
   logic [7:0] run_len;
   logic [7:0] err_count;

   logic       r3_locked, r3_lock_pulse, r3_unlock_pulse;
   logic [1:0] r3_state;
   logic [2:0] r3_run_len;
   logic [7:0] r3_err_count;

   logic       u1_locked, u1_lock_pulse, u1_unlock_pulse;
   logic [1:0] u1_state;
   logic [7:0] u1_run_len;
   logic [7:0] u1_err_count;

   int vectors;
   int miscompares;

   eq_lock_tracker dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid), .eq(eq),
      .locked(locked), .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse),
      .state(state), .run_len(run_len), .err_count(err_count)
   );

   eq_lock_tracker #(.RUN_W(3)) dut_r3 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid), .eq(eq),
      .locked(r3_locked), .lock_pulse(r3_lock_pulse),
      .unlock_pulse(r3_unlock_pulse), .state(r3_state),
      .run_len(r3_run_len), .err_count(r3_err_count)
   );

   eq_lock_tracker #(.UNLOCK_COUNT(1)) dut_u1 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid), .eq(eq),
      .locked(u1_locked), .lock_pulse(u1_lock_pulse),
      .unlock_pulse(u1_unlock_pulse), .state(u1_state),
      .run_len(u1_run_len), .err_count(u1_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample, let it be clocked in, sample outputs 1 time unit later.
   task automatic apply(input logic v, input logic e);
      valid = v;
      eq    = e;
      @(posedge clk);
      #1;
      $display("t=%0t valid=%0b eq=%0b -> state=%0d run=%0d err=%0d lk=%0b lp=%0b up=%0b",
               $time, v, e, state, run_len, err_count, locked, lock_pulse,
               unlock_pulse);
   endtask

   // Compact check of the default instance.
   task automatic check_main(input string tag, input logic [1:0] st,
                             input logic [7:0] rl, input logic [7:0] ec,
                             input logic lk, input logic lp, input logic up);
      check({tag, ".state"},  32'(state),        32'(st));
      check({tag, ".run"},    32'(run_len),      32'(rl));
      check({tag, ".err"},    32'(err_count),    32'(ec));
      check({tag, ".locked"}, 32'(locked),       32'(lk));
      check({tag, ".lpulse"}, 32'(lock_pulse),   32'(lp));
      check({tag, ".upulse"}, 32'(unlock_pulse), 32'(up));
   endtask

   initial begin
      logic [7:0] seq_eq;
      logic [7:0] seq_run [8];
      logic [6:0] gap_v;
      logic [7:0] gap_run [7];

      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      clear       = 1'b0;
      valid       = 1'b0;
      eq          = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_main("reset", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // Lock acquisition: eq = 1,1,1,0,1,1,1,1 (first sample is bit 0)
      seq_eq  = 8'b1111_0111;
      seq_run = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, seq_eq[i]);
         check($sformatf("acq%0d.run", i), 32'(run_len), 32'(seq_run[i]));
         check($sformatf("acq%0d.lpulse", i), 32'(lock_pulse),
               (i == 7) ? 32'd1 : 32'd0);
      end
      check_main("acq_end", 2'b01, 8'd4, 8'd1, 1'b1, 1'b1, 1'b0);
      check("acq_end.r3_state", 32'(r3_state), 32'd1);

      // Idle cycle: everything holds, pulse drops.
      apply(1'b0, 1'b1);
      check_main("idle", 2'b01, 8'd4, 8'd1, 1'b1, 1'b0, 1'b0);

      // Slip then recover.
      apply(1'b1, 1'b0);
      check_main("slip", 2'b10, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0);
      check("u1_direct.state",  32'(u1_state),        32'd0);
      check("u1_direct.upulse", 32'(u1_unlock_pulse), 32'd1);
      check("u1_direct.locked", 32'(u1_locked),       32'd0);
      apply(1'b1, 1'b1);
      check_main("recover", 2'b01, 8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
      check("u1_recover.state", 32'(u1_state), 32'd0);

      // Unlock: two mismatches from LOCKED.
      apply(1'b1, 1'b0);
      check_main("unlock1", 2'b10, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b0);
      check_main("unlock2", 2'b00, 8'd0, 8'd4, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0);
      check_main("unlock_idle", 2'b00, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0);

      // Valid gaps: valid 1,0,0,1,0,1,1 with eq=1 (first sample is bit 0).
      gap_v   = 7'b110_1001;
      gap_run = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4};
      for (int i = 0; i < 7; i++) begin
         apply(gap_v[i], 1'b1);
         check($sformatf("gap%0d.run", i), 32'(run_len), 32'(gap_run[i]));
         check($sformatf("gap%0d.lpulse", i), 32'(lock_pulse),
               (i == 6) ? 32'd1 : 32'd0);
      end
      check_main("gap_end", 2'b01, 8'd4, 8'd4, 1'b1, 1'b1, 1'b0);

      // Enter SLIP, then assert reset between edges.
      apply(1'b1, 1'b0);
      check_main("pre_rst_slip", 2'b10, 8'd0, 8'd5, 1'b1, 1'b0, 1'b0);
      valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_main("async_rst", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      apply(1'b1, 1'b1);
      check_main("post_rst", 2'b00, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);

      // err_count saturation: 300 mismatches.
      for (int i = 0; i < 300; i++) begin
         valid = 1'b1;
         eq    = 1'b0;
         @(posedge clk);
         #1;
         if (i == 254) check("err_at255", 32'(err_count), 32'd255);
      end
      check("err_sat", 32'(err_count), 32'd255);
      check("err_sat.r3", 32'(r3_err_count), 32'd255);

      // run_len saturation with RUN_W=3: 10 matches.
      for (int i = 0; i < 10; i++) begin
         valid = 1'b1;
         eq    = 1'b1;
         @(posedge clk);
         #1;
         if (i == 6) check("r3_run_at7", 32'(r3_run_len), 32'd7);
      end
      check("run_sat.r3", 32'(r3_run_len), 32'd7);
      check("run_sat.main", 32'(run_len), 32'd10);
      check("run_sat.r3_state", 32'(r3_state), 32'd1);

      // Clear together with a valid mismatch: clear wins.
      clear = 1'b1;
      apply(1'b1, 1'b0);
      check_main("clear", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      clear = 1'b0;
      apply(1'b1, 1'b0);
      check_main("after_clear", 2'b00, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
